// File: rtl/mgt_01_mul_controller_pkg.sv
// Shared types and constants for the iterative multiply unit.
package mgt_01_mul_controller_pkg;

  localparam int XLEN        = 32;
  localparam int EXT_W       = XLEN + 1;        // operand width after sign/zero extension
  localparam int PROD_W      = 2 * EXT_W;       // full Booth product width
  localparam int BOOTH_STEPS = (XLEN + 2) / 2;  // radix-4 digits of an EXT_W-bit multiplier
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {MUL_, MULH_, MULHSU_, MULHU_} mul_ops_e;
  typedef enum logic       {FREE, BUSY} fu_state_e;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} ctrl_state_e;

  // Widen an operand by one bit, replicating the sign only when it is signed.
  function automatic logic [EXT_W-1:0] ext_op(input logic [XLEN-1:0] v, input logic sgn);
    return {sgn & v[XLEN-1], v};
  endfunction

endpackage

// File: rtl/mgt_01_mul_controller_if.sv
// Request/result bundle between an issuing stage and the multiply unit.
interface mgt_01_mul_controller_if #(parameter int TAG_W = 5);
  import mgt_01_mul_controller_pkg::*;

  logic             req_valid_i;
  logic             req_ready_o;
  mul_ops_e         op_i;
  logic [XLEN-1:0]  op_a_i;
  logic [XLEN-1:0]  op_b_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [XLEN-1:0]  res_data_o;
  logic [TAG_W-1:0] res_tag_o;
  fu_state_e        fu_state_o;

  modport master (
    output req_valid_i, op_i, op_a_i, op_b_i, tag_i, flush_i, res_ready_i,
    input  req_ready_o, res_valid_o, res_data_o, res_tag_o, fu_state_o
  );

  modport slave (
    input  req_valid_i, op_i, op_a_i, op_b_i, tag_i, flush_i, res_ready_i,
    output req_ready_o, res_valid_o, res_data_o, res_tag_o, fu_state_o
  );

endinterface

// File: rtl/mgt_01_booth_core.sv
// Sequential signed radix-4 Booth multiplier: one recoded digit per step.
module mgt_01_booth_core
  import mgt_01_mul_controller_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load,
  input  logic              step,
  input  logic [EXT_W-1:0]  op_a,
  input  logic [EXT_W-1:0]  op_b,
  output logic [PROD_W-1:0] product,
  output logic              done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BOOTH_STEPS - 1);

  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] mcand;   // multiplicand, pre-shifted to the current digit weight
  logic [EXT_W+1:0]  mplr;    // {sign, multiplier, 0}; low 3 bits are the current Booth window
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] pp;

  // Booth digit select: 0, +-M, +-2M from the 3-bit window.
  always_comb begin
    pp = '0;
    case (mplr[2:0])
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end

  // Load clears the accumulator and counter; each step accumulates one digit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= {{(PROD_W-EXT_W){op_a[EXT_W-1]}}, op_a};
      mplr  <= {op_b[EXT_W-1], op_b, 1'b0};
      cnt   <= '0;
    end else if (step) begin
      acc   <= acc + pp;
      mcand <= mcand << 2;
      mplr  <= {{2{mplr[EXT_W+1]}}, mplr[EXT_W+1:2]};
      if (cnt != LAST) cnt <= cnt + 1'b1;
    end
  end

  assign product = acc;
  assign done    = (cnt == LAST);

endmodule

// File: rtl/mgt_01_mul_controller.sv
// Multiply functional unit: handshakes, operand extension, control FSM and result select
// around the iterative Booth core.
module mgt_01_mul_controller
  import mgt_01_mul_controller_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input logic clk_i,
  input logic rst_n_i,
  mgt_01_mul_controller_if.slave bus
);

  ctrl_state_e       state, state_nxt;
  mul_ops_e          op_q;
  logic [TAG_W-1:0]  tag_q;
  logic              zero_q;      // result is known zero, core output ignored

  logic              req_ready;
  logic              accept;
  logic              op_zero;
  logic              a_sgn, b_sgn;
  logic [EXT_W-1:0]  a_ext, b_ext;
  logic              core_load, core_step, core_done;
  logic [PROD_W-1:0] product;
  logic [XLEN-1:0]   res_sel;
  logic              res_valid;

  assign req_ready = (state == ST_IDLE) && !bus.flush_i;
  assign accept    = bus.req_valid_i && req_ready;
  assign op_zero   = (bus.op_a_i == '0) || (bus.op_b_i == '0);

  // MULHU treats rs1 as unsigned; MULHSU and MULHU treat rs2 as unsigned.
  assign a_sgn = (bus.op_i != MULHU_);
  assign b_sgn = (bus.op_i == MUL_) || (bus.op_i == MULH_);
  // Non-accept loads come from a flush and should leave the datapath cleared.
  assign a_ext = accept ? ext_op(bus.op_a_i, a_sgn) : '0;
  assign b_ext = accept ? ext_op(bus.op_b_i, b_sgn) : '0;

  assign core_load = accept || (bus.flush_i && (state != ST_IDLE));
  assign core_step = (state == ST_BUSY) && !bus.flush_i;

  mgt_01_booth_core u_core (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load    (core_load),
    .step    (core_step),
    .op_a    (a_ext),
    .op_b    (b_ext),
    .product (product),
    .done    (core_done)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state: flush beats everything, zero operands skip the iteration.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)                     state_nxt = op_zero ? ST_DONE : ST_BUSY;
      ST_BUSY: if (bus.flush_i)                state_nxt = ST_IDLE;
               else if (core_done)             state_nxt = ST_DONE;
      ST_DONE: if (bus.flush_i || bus.res_ready_i) state_nxt = ST_IDLE;
      default:                                 state_nxt = ST_IDLE;
    endcase
  end

  // Request side-band captured at acceptance and held until the next one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q   <= MUL_;
      tag_q  <= '0;
      zero_q <= 1'b0;
    end else if (accept) begin
      op_q   <= bus.op_i;
      tag_q  <= bus.tag_i;
      zero_q <= op_zero;
    end
  end

  assign res_valid = (state == ST_DONE);
  assign res_sel   = (op_q == MUL_) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  assign bus.req_ready_o = req_ready;
  assign bus.res_valid_o = res_valid;
  assign bus.res_data_o  = (res_valid && !zero_q) ? res_sel : '0;
  assign bus.res_tag_o   = res_valid ? tag_q : '0;
  assign bus.fu_state_o  = (state == ST_IDLE) ? FREE : BUSY;

endmodule

// File: tb/tb_mgt_01_mul_controller.sv
// Scoreboard bench for the multiply unit: a driver pushes expected results, a monitor
// pops and checks whenever the unit presents one.
module tb_mgt_01_mul_controller;
  import mgt_01_mul_controller_pkg::*;

  localparam int TAG_W = 5;

  typedef struct {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
    int               lat;      // cycles from accept until res_valid (1 = next cycle)
    int               acc;      // index of the accepting clock edge
    bit               discard;  // result is expected to be flushed, not delivered
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ready_mode = 0;   // 0 random, 1 hold low, 2 hold high
  exp_t sb_q[$];

  mgt_01_mul_controller_if #(.TAG_W(TAG_W)) bus();

  mgt_01_mul_controller #(.TAG_W(TAG_W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Reference: plain 64-bit arithmetic on the operands interpreted per opcode.
  function automatic logic [XLEN-1:0] ref_mul(input mul_ops_e op, input logic [31:0] a,
                                              input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    sa = (op == MULHU_) ? $signed({32'h0, a}) : $signed({{32{a[31]}}, a});
    sb = (op == MUL_ || op == MULH_) ? $signed({{32{b[31]}}, b}) : $signed({32'h0, b});
    p  = sa * sb;
    return (op == MUL_) ? p[31:0] : p[63:32];
  endfunction

  // Result ready pattern.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       bus.res_ready_i = ($urandom_range(0, 2) != 0);
      1:       bus.res_ready_i = 1'b0;
      default: bus.res_ready_i = 1'b1;
    endcase
  end

  // Monitor: latency, hold-while-stalled, zero-when-idle, and scoreboard pop.
  initial begin
    logic            prev_valid;
    logic [XLEN-1:0]  prev_data;
    logic [TAG_W-1:0] prev_tag;
    exp_t e;
    prev_valid = 1'b0;
    prev_data  = '0;
    prev_tag   = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.res_valid_o) begin
          check("fu_state_in_done", 64'(bus.fu_state_o), 64'(BUSY));
          if (!prev_valid) begin
            if (sb_q.size() == 0) flag("unexpected_result", "res_valid high, no result expected");
            else check("latency", 64'(cyc), 64'(sb_q[0].acc + sb_q[0].lat - 1));
          end else begin
            check("hold_data", 64'(bus.res_data_o), 64'(prev_data));
            check("hold_tag", 64'(bus.res_tag_o), 64'(prev_tag));
          end
          if (bus.flush_i || bus.res_ready_i) begin
            if (sb_q.size() == 0) flag("pop_empty", "result consumed with empty scoreboard");
            else begin
              e = sb_q.pop_front();
              if (bus.flush_i) check("flush_discard", 64'(e.discard), 64'd1);
              else begin
                check("delivered_not_discarded", 64'(e.discard), 64'd0);
                check("res_data", 64'(bus.res_data_o), 64'(e.data));
                check("res_tag", 64'(bus.res_tag_o), 64'(e.tag));
              end
            end
          end
        end else begin
          check("data_zero_idle", 64'(bus.res_data_o), 64'd0);
          check("tag_zero_idle", 64'(bus.res_tag_o), 64'd0);
        end
      end
      prev_valid = rst_n && bus.res_valid_o;
      prev_data  = bus.res_data_o;
      prev_tag   = bus.res_tag_o;
    end
  end

  // Present one request until accepted; optionally record its expected result.
  task automatic issue(input mul_ops_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp_data,
                       input bit push, input bit discard);
    int waited;
    bit done;
    exp_t e;
    waited = 0;
    done   = 1'b0;
    @(posedge clk); #1;
    bus.op_i = op; bus.op_a_i = a; bus.op_b_i = b; bus.tag_i = tag;
    bus.req_valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.req_ready_o) begin
        done = 1'b1;
        if (push) begin
          e.data = exp_data; e.tag = tag; e.lat = (a == 0 || b == 0) ? 1 : 18;
          e.acc = cyc + 1; e.discard = discard;
          sb_q.push_back(e);
        end
      end else if (++waited > 200) begin
        flag("issue_timeout", "req_ready_o stayed low for 200 cycles");
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.req_valid_i = 1'b0;
    bus.op_a_i = $urandom; bus.op_b_i = $urandom; bus.tag_i = TAG_W'($urandom);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.res_valid_o && n < 100) begin @(negedge clk); n++; end
    if (!bus.res_valid_o) flag(name, "res_valid_o never rose within 100 cycles");
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    mul_ops_e op;
    logic [31:0] a, b;
    int n;
    bus.req_valid_i = 1'b0; bus.op_i = MUL_; bus.op_a_i = '0; bus.op_b_i = '0;
    bus.tag_i = '0; bus.flush_i = 1'b0; bus.res_ready_i = 1'b0;

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(bus.res_valid_o), 64'd0);
    check("rst_data", 64'(bus.res_data_o), 64'd0);
    check("rst_tag", 64'(bus.res_tag_o), 64'd0);
    check("rst_fu_state", 64'(bus.fu_state_o), 64'(FREE));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);

    // Directed arithmetic corners.
    issue(MUL_,    32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 1, 0);
    issue(MULH_,   32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 1, 0);
    issue(MULHU_,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 1, 0);
    issue(MULHSU_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, 1, 0);
    issue(MULHSU_, 32'd2,        32'h8000_0000, 5'd7,  32'h0000_0001, 1, 0);
    issue(MUL_,    32'd0,        32'h1234_5678, 5'd8,  32'h0,         1, 0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      op = mul_ops_e'($urandom_range(0, 3));
      a  = rand_opnd();
      b  = rand_opnd();
      issue(op, a, b, TAG_W'($urandom), ref_mul(op, a, b), 1, 0);
    end

    // Flush five cycles into the iteration: nothing is delivered.
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    issue(MUL_, 32'h1234, 32'h5678, 5'd9, 32'h0, 0, 0);
    repeat (4) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(negedge clk);
    check("busy_before_flush", 64'(bus.fu_state_o), 64'(BUSY));
    @(posedge clk); #1 bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_busy_ready", 64'(bus.req_ready_o), 64'd1);
    check("flush_busy_no_valid", 64'(bus.res_valid_o), 64'd0);
    repeat (25) @(negedge clk);

    // Flush together with a request in IDLE: the request is not taken.
    @(posedge clk); #1;
    bus.op_i = MUL_; bus.op_a_i = 32'd3; bus.op_b_i = 32'd4; bus.req_valid_i = 1'b1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_idle_ready", 64'(bus.req_ready_o), 64'd0);
    @(posedge clk); #1 bus.req_valid_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_idle_no_accept", 64'(bus.fu_state_o), 64'(FREE));

    // Flush in DONE wins over a concurrent res_ready_i.
    ready_mode = 1;
    issue(MUL_, 32'd0, 32'd5, 5'd10, 32'h0, 1, 1);
    @(negedge clk);
    ready_mode = 2;
    @(posedge clk); #1 bus.flush_i = 1'b1;
    @(posedge clk); #1 bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_done_idle", 64'(bus.fu_state_o), 64'(FREE));

    // Ten cycles of backpressure in DONE, then the handshake returns to IDLE.
    ready_mode = 1;
    issue(MULH_, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd11,
          ref_mul(MULH_, 32'hDEAD_BEEF, 32'hCAFE_F00D), 1, 0);
    wait_valid("bp_valid_timeout");
    repeat (10) @(negedge clk);
    check("bp_still_valid", 64'(bus.res_valid_o), 64'd1);
    ready_mode = 2;
    n = 0;
    while (bus.res_valid_o && n < 20) begin @(negedge clk); n++; end
    check("bp_idle_fu_state", 64'(bus.fu_state_o), 64'(FREE));
    check("bp_idle_ready", 64'(bus.req_ready_o), 64'd1);
    ready_mode = 0;

    // Reset mid-iteration takes effect without a clock edge.
    issue(MULHU_, 32'hDEAD_BEEF, 32'h0001_2345, 5'd12, 32'h0, 0, 0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.res_valid_o), 64'd0);
    check("midrst_data", 64'(bus.res_data_o), 64'd0);
    check("midrst_tag", 64'(bus.res_tag_o), 64'd0);
    check("midrst_fu_state", 64'(bus.fu_state_o), 64'(FREE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(bus.req_ready_o), 64'd1);
    issue(MULHSU_, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13,
          ref_mul(MULHSU_, 32'h8000_0000, 32'hFFFF_FFFF), 1, 0);

    // Drain.
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (sb_q.size() != 0) flag("drain_timeout", $sformatf("%0d results still pending", sb_q.size()));
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mgt_01_mul_controller.md
MGT_01_MUL_CONTROLLER -- requirements
Module: mgt_01_mul_controller

Interface
REQ-001 Parameter: XLEN, 32 (from shared package), operand and result width.
REQ-002 Parameter: TAG_W, 5, width of the destination-register tag carried with each request.
REQ-003 Clocking and reset SHALL be one clock and an asynchronous active-low reset, as follows:
  - clk_i  in  1  rising-edge clock.
  - rst_n_i  in  1  asynchronous reset, active low.
REQ-004 Request and result ports SHALL be as follows:
  - req_valid_i  in  1  request present.
  - req_ready_o  out  1  request accepted when high together with req_valid_i.
  - op_i  in  mul_ops_e  MUL_/MULH_/MULHSU_/MULHU_.
  - op_a_i  in  XLEN  rs1 operand.
  - op_b_i  in  XLEN  rs2 operand.
  - tag_i  in  TAG_W  destination tag.
  - flush_i  in  1  abort in-flight operation.
  - res_valid_o  out  1  result present.
  - res_ready_i  in  1  result consumed when high together with res_valid_o.
  - res_data_o  out  XLEN  result word.
  - res_tag_o  out  TAG_W  tag of the result.
  - fu_state_o  out  fu_state_e  FREE when idle, otherwise BUSY.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-006 req_ready_o SHALL equal (state==IDLE) and not flush_i; acceptance happens on the clock edge where req_valid_i and req_ready_o are both high.
REQ-007 On acceptance, op, tag and operands SHALL be latched. op_a SHALL be extended to XLEN+1 bits: sign-extended for MUL_/MULH_/MULHSU_, zero-extended for MULHU_.
REQ-008 On acceptance, op_b SHALL be extended to XLEN+1 bits: sign-extended for MUL_/MULH_, zero-extended for MULHSU_/MULHU_.
REQ-009 The core SHALL form a signed (XLEN+1)x(XLEN+1) radix-4 Booth product, 2*XLEN+2 bits wide, one recoding step per cycle, for (XLEN+2)/2 = 17 steps. A 5-bit step counter SHALL count 0..16.
REQ-010 Zero bypass: if either latched operand is zero, the FSM SHALL go IDLE->DONE with result 0, so res_valid_o is high one cycle after acceptance.
REQ-011 Normal latency: res_valid_o SHALL assert 18 cycles after the acceptance edge. BUSY->DONE SHALL occur on the edge where the counter equals 16.
REQ-012 Result select: MUL_ SHALL return product[XLEN-1:0]; MULH_/MULHSU_/MULHU_ SHALL return product[2*XLEN-1:XLEN].
REQ-013 In DONE, res_valid_o, res_data_o and res_tag_o SHALL hold stable until res_ready_i is high. The handshake edge SHALL move the FSM to IDLE.
REQ-014 No new request SHALL be accepted in the same cycle as a result handshake; the minimum issue interval is 2 cycles for bypass and 19 cycles for the normal path.
REQ-015 flush_i high in BUSY or DONE SHALL return the FSM to IDLE on the next edge, drop res_valid_o, and clear the counter. A flush in DONE SHALL discard the result even if res_ready_i is high.
REQ-016 flush_i together with req_valid_i in IDLE: flush SHALL win and no request is accepted.
REQ-017 fu_state_o SHALL be FREE only in IDLE.
REQ-018 res_data_o and res_tag_o SHALL be 0 whenever res_valid_o is low.

Reset
REQ-019 Asserting rst_n_i SHALL immediately force, at any time including mid-operation, the following:
  - state = IDLE, counter = 0, all datapath registers = 0.
  - req_ready_o = 1 once rst_n_i deasserts.
  - res_valid_o = 0, res_data_o = 0, res_tag_o = 0.
  - fu_state_o = FREE.

Structure
REQ-020 XLEN, mul_ops_e and fu_state_e SHALL come from the shared package. A ctrl_state_e enum (IDLE/BUSY/DONE) SHALL be added to the same package.
REQ-021 The Booth iteration datapath SHALL be one sub-module, mgt_01_booth_core, with these ports:
  - inputs: load, step, operands.
  - outputs: product, done.
  The FSM, handshakes, operand extension and result mux SHALL live in the top module.

Verification
REQ-022 MUL_ 7 x 0xFFFFFFFD -> res_data_o 0xFFFFFFEB, res_valid_o 18 cycles after accept, res_tag_o equal to the issued tag.
REQ-023 MULH_ 0x80000000 x 0x80000000 -> 0x40000000; MULHU_ 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-024 MULHSU_ 0xFFFFFFFF (signed -1) x 0xFFFFFFFF (unsigned) -> 0xFFFFFFFF; MULHSU_ 2 x 0x80000000 -> 0x00000001.
REQ-025 MUL_ 0 x 0x12345678 -> res_valid_o 1 cycle after accept, data 0, fu_state_o BUSY during DONE.
REQ-026 Flush checks:
  - flush_i 5 cycles into BUSY -> no res_valid_o, req_ready_o high next cycle.
  - flush_i with req_valid_i in IDLE -> no acceptance.
REQ-027 Backpressure and reset checks:
  - res_ready_i low for 10 cycles in DONE -> outputs stable, then handshake -> IDLE.
  - rst_n_i low mid-BUSY -> all outputs at reset values immediately.
